// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and helpers for the programmable counter/timer blocks
package counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Widest counter the shared clamp helper supports; callers zero-extend into it.
  localparam int CLAMP_MAX_W = 32;

  function automatic logic [CLAMP_MAX_W-1:0] clamp_tc(input logic [CLAMP_MAX_W-1:0] val,
                                                       input logic [CLAMP_MAX_W-1:0] tc);
    return (val > tc) ? tc : val;
  endfunction

endpackage

// File: rtl/prog_mod_counter.sv
// rtl/prog_mod_counter.sv - runtime-programmable modulus counter, up/down, free-run or one-shot
module prog_mod_counter
  import counter_pkg::*;
#(
  parameter int W       = 8,
  parameter int M_RESET = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         oneshot,
  input  logic         tc_wr,
  input  logic [W-1:0] tc_in,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q,
  output logic         at_tc,
  output logic         wrap_tick,
  output logic         done
);

  if (W < 1 || W > CLAMP_MAX_W) begin : g_bad_w
    $error("prog_mod_counter: W out of range");
  end
  if (M_RESET < 1 || (W < 31 && M_RESET > (1 << W))) begin : g_bad_m
    $error("prog_mod_counter: M_RESET out of range 1..2**W");
  end

  localparam logic [W-1:0] TC_RESET = W'(M_RESET - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] tc_q, tc_d;
  logic         done_q, done_d;
  logic [W-1:0] ld_limit;
  logic         step;
  logic         term;
  dir_e         dir_s;

  always_comb begin
    dir_s    = dir_e'(dir);
    term     = (dir_s == DIR_UP) ? (cnt_q >= tc_q) : (cnt_q == '0);
    step     = en & ~done_q & ~ld & ~reset;
    tc_d     = tc_wr ? tc_in : tc_q;
    ld_limit = tc_wr ? tc_in : tc_q;
    cnt_d    = cnt_q;
    done_d   = done_q;

    if (ld) begin
      cnt_d  = W'(clamp_tc(CLAMP_MAX_W'(ld_val), CLAMP_MAX_W'(ld_limit)));
      done_d = 1'b0;
    end else begin
      if (!oneshot) begin
        done_d = 1'b0;
      end
      if (step) begin
        // Arithmetic only on the non-terminal path, so full-range wrap never overflows.
        if (term) begin
          if (oneshot) begin
            done_d = 1'b1;
          end else begin
            cnt_d = (dir_s == DIR_UP) ? '0 : tc_q;
          end
        end else if (dir_s == DIR_UP) begin
          cnt_d = cnt_q + W'(1);
        end else begin
          cnt_d = (cnt_q > tc_q) ? tc_q : cnt_q - W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tc_q   <= TC_RESET;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      done_q <= done_d;
    end
  end

  assign q         = cnt_q;
  assign at_tc     = term;
  assign wrap_tick = step & term;
  assign done      = done_q;

endmodule

// File: tb/tb_prog_mod_counter.sv
// tb/tb_prog_mod_counter.sv - directed self-checking bench for prog_mod_counter
module tb_prog_mod_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         dir;
  logic         oneshot;
  logic         tc_wr;
  logic [W-1:0] tc_in;
  logic         ld;
  logic [W-1:0] ld_val;
  logic [W-1:0] q;
  logic         at_tc;
  logic         wrap_tick;
  logic         done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prog_mod_counter #(.W(W), .M_RESET(10)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .oneshot(oneshot),
    .tc_wr(tc_wr), .tc_in(tc_in), .ld(ld), .ld_val(ld_val),
    .q(q), .at_tc(at_tc), .wrap_tick(wrap_tick), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] tc, input logic [W-1:0] val);
    tc_wr = 1'b1; tc_in = tc; ld = 1'b1; ld_val = val;
    tick();
    tc_wr = 1'b0; ld = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; dir = 1'b0; oneshot = 1'b0;
    tc_wr = 1'b0; tc_in = '0; ld = 1'b0; ld_val = '0;
    #1;
    chk("wrap_in_reset", 32'(wrap_tick), 0);
    tick();
    tick();
    chk("rst_q", 32'(q), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wrap", 32'(wrap_tick), 0);
    chk("rst_at_tc", 32'(at_tc), 0);

    // Free-run UP, default modulus 10
    reset = 1'b0;
    #1;
    for (int i = 0; i < 25; i++) begin
      chk("up_q", 32'(q), 32'(i % 10));
      chk("up_wrap", 32'(wrap_tick), (i % 10 == 9) ? 1 : 0);
      tick();
    end

    // DOWN with tc=4, load 2 in the same cycle as the tc write
    dir = 1'b1;
    load(8'd4, 8'd2);
    begin
      int exp_dn[9] = '{2, 1, 0, 4, 3, 2, 1, 0, 4};
      for (int i = 0; i < 9; i++) begin
        chk("dn_q", 32'(q), 32'(exp_dn[i]));
        chk("dn_wrap", 32'(wrap_tick), (exp_dn[i] == 0) ? 1 : 0);
        tick();
      end
    end

    // One-shot UP, tc=3
    dir = 1'b0;
    en = 1'b0;
    load(8'd3, 8'd0);
    oneshot = 1'b1; en = 1'b1;
    #1;
    begin
      int exp_os[6]   = '{0, 1, 2, 3, 3, 3};
      int exp_wr[6]   = '{0, 0, 0, 1, 0, 0};
      int exp_done[6] = '{0, 0, 0, 0, 1, 1};
      for (int i = 0; i < 6; i++) begin
        chk("os_q", 32'(q), 32'(exp_os[i]));
        chk("os_wrap", 32'(wrap_tick), 32'(exp_wr[i]));
        chk("os_done", 32'(done), 32'(exp_done[i]));
        tick();
      end
    end
    ld = 1'b1; ld_val = 8'd1;
    tick();
    ld = 1'b0;
    chk("os_ld_done", 32'(done), 0);
    chk("os_ld_q", 32'(q), 1);
    tick();
    chk("os_resume_q", 32'(q), 2);

    // Lowering tc below the current count
    oneshot = 1'b0; en = 1'b0;
    tick();
    load(8'd255, 8'd200);
    chk("hi_ld_q", 32'(q), 200);
    en = 1'b1; tc_wr = 1'b1; tc_in = 8'd50;
    tick();
    tc_wr = 1'b0;
    chk("old_tc_q", 32'(q), 201);
    chk("above_tc_at", 32'(at_tc), 1);
    chk("above_tc_wrap", 32'(wrap_tick), 1);
    tick();
    chk("above_tc_next", 32'(q), 0);
    en = 1'b0; ld = 1'b1; ld_val = 8'd99;
    tick();
    ld = 1'b0;
    chk("ld_clamp", 32'(q), 50);

    // Modulus 1: q stuck at 0, wrap_tick follows en in both directions
    load(8'd0, 8'd0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dir = (i >= 2);
      #1;
      chk("m1_q", 32'(q), 0);
      chk("m1_wrap", 32'(wrap_tick), 1);
      tick();
    end
    en = 1'b0;
    #1;
    chk("m1_wrap_en0", 32'(wrap_tick), 0);

    // en toggling 1,0,1
    dir = 1'b0;
    load(8'd9, 8'd0);
    en = 1'b1; tick(); chk("en1_q", 32'(q), 1);
    en = 1'b0; tick(); chk("en0_q", 32'(q), 1);
    en = 1'b1; tick(); chk("en1b_q", 32'(q), 2);

    // Full-range modulus 256
    en = 1'b0;
    load(8'd255, 8'd254);
    en = 1'b1;
    #1;
    chk("fr_q254", 32'(q), 254);
    chk("fr_wrap254", 32'(wrap_tick), 0);
    tick();
    chk("fr_q255", 32'(q), 255);
    chk("fr_wrap255", 32'(wrap_tick), 1);
    tick();
    chk("fr_q0", 32'(q), 0);
    dir = 1'b1;
    #1;
    chk("fr_dn_wrap", 32'(wrap_tick), 1);
    tick();
    chk("fr_dn_q", 32'(q), 255);

    // Reset mid-count at q=7 with a pending tc write
    dir = 1'b0; en = 1'b0;
    load(8'd9, 8'd7);
    chk("pre_rst_q", 32'(q), 7);
    en = 1'b1; reset = 1'b1; tc_wr = 1'b1; tc_in = 8'd3;
    #1;
    chk("rst_mid_wrap", 32'(wrap_tick), 0);
    tick();
    reset = 1'b0; tc_wr = 1'b0; en = 1'b0;
    chk("rst_mid_q", 32'(q), 0);
    chk("rst_mid_done", 32'(done), 0);
    ld = 1'b1; ld_val = 8'd200;
    tick();
    ld = 1'b0;
    chk("rst_mid_tc", 32'(q), 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
